cache_bus_arbiter: RTL and testbench

CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

---
 rtl/cache_arb_pkg.sv | 44 ++++
 rtl/arb_line_packer.sv | 53 +++++
 rtl/cache_bus_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_cache_bus_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and line/beat helpers for the cache bus arbiter.
package cache_arb_pkg;

  localparam int unsigned LINE_W = 128;
  localparam int unsigned BEAT_W = 32;
  localparam int unsigned BEATS  = LINE_W / BEAT_W;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } arb_state_e;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ICACHE,
    SRC_DCACHE
  } src_e;

  function automatic logic [LINE_W-1:0] insert_beat(input logic [LINE_W-1:0] line,
                                                    input logic [1:0]        idx,
                                                    input logic [BEAT_W-1:0] beat);
    logic [LINE_W-1:0] r;
    r = line;
    for (int unsigned i = 0; i < BEATS; i++) begin
      if (idx == i[1:0]) r[i*BEAT_W +: BEAT_W] = beat;
    end
    return r;
  endfunction

  function automatic logic [BEAT_W-1:0] select_beat(input logic [LINE_W-1:0] line,
                                                    input logic [1:0]        idx);
    logic [BEAT_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < BEATS; i++) begin
      if (idx == i[1:0]) r = line[i*BEAT_W +: BEAT_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_line_packer.sv
// Beat counter plus line buffer: assembles read beats into a line and
// serializes a write-back line into beats, lowest word first.
module arb_line_packer
  import cache_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [LINE_W-1:0] load_line_i,
  input  logic              beat_i,
  input  logic [BEAT_W-1:0] beat_data_i,
  input  logic              adv_i,
  input  logic [1:0]        len_i,
  output logic [LINE_W-1:0] line_merged_o,
  output logic [BEAT_W-1:0] wr_beat_o,
  output logic              at_len_o
);

  logic [1:0]        cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;

  assign at_len_o      = (cnt_q == len_i);
  assign line_merged_o = insert_beat(line_q, cnt_q, beat_data_i);
  assign wr_beat_o     = select_beat(line_q, cnt_q);

  // Counter saturates at len so stray beats before 'last' cannot wrap.
  always_comb begin
    cnt_d  = cnt_q;
    line_d = line_q;
    if (clear_i) begin
      cnt_d  = '0;
      line_d = '0;
    end else if (load_i) begin
      cnt_d  = '0;
      line_d = load_line_i;
    end else begin
      if (beat_i) line_d = line_merged_o;
      if ((beat_i || adv_i) && !at_len_o) cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Arbitrates ICache/DCache refills and DCache write-backs onto one memory port.
// Define ARB_RR_EN for round-robin read arbitration (fixed priority otherwise).
module cache_bus_arbiter
  import cache_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                irq_req_i,
  input  logic [31:0]         icache_rd_addr_i,
  input  logic [7:0]          icache_rd_len_i,
  output logic                icache_ret_valid_o,
  output logic [LINE_W-1:0]   icache_ret_data_o,
  input  logic                dcache_rd_req_i,
  input  logic [31:0]         dcache_rd_addr_i,
  input  logic [7:0]          dcache_rd_len_i,
  output logic                dcache_ret_valid_o,
  output logic [LINE_W-1:0]   dcache_ret_data_o,
  input  logic                dcache_wr_req_i,
  input  logic [31:0]         dcache_wr_addr_i,
  input  logic [LINE_W-1:0]   dcache_wr_data_i,
  input  logic [7:0]          dcache_wr_len_i,
  output logic                dcache_wr_rdy_o,
  output logic                mem_rd_req_o,
  output logic [31:0]         mem_rd_addr_o,
  output logic [7:0]          mem_rd_len_o,
  input  logic                mem_rd_rdy_i,
  input  logic                mem_ret_valid_i,
  input  logic                mem_ret_last_i,
  input  logic [BEAT_W-1:0]   mem_ret_data_i,
  output logic                mem_wr_req_o,
  output logic [31:0]         mem_wr_addr_o,
  output logic [7:0]          mem_wr_len_o,
  input  logic                mem_wr_rdy_i,
  output logic                mem_wdata_valid_o,
  output logic [BEAT_W-1:0]   mem_wdata_o,
  output logic                mem_wdata_last_o,
  input  logic                mem_wdata_rdy_i,
  input  logic                mem_wr_done_i
);

  arb_state_e        state_q, state_d;
  src_e              src_q, src_d;
  logic [31:0]       addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic              ic_valid_q, ic_valid_d, dc_valid_q, dc_valid_d;
  logic [LINE_W-1:0] ic_line_q, ic_line_d, dc_line_q, dc_line_d;

  logic              pk_clear, pk_load, pk_beat, pk_adv, pk_at_len;
  logic [LINE_W-1:0] pk_merged;
  logic [BEAT_W-1:0] pk_wr_beat;
  logic              pick_ic, pick_dc, ret_pending, rd_grant;

  // Requesters hold their request through the return pulse, so reads are not
  // granted in that cycle to avoid serving the same request twice.
  assign ret_pending = ic_valid_q || dc_valid_q;

`ifdef ARB_RR_EN
  src_e last_rd_q, last_rd_d;
  assign pick_ic = irq_req_i && (!dcache_rd_req_i || last_rd_q == SRC_DCACHE);

  always_comb begin
    last_rd_d = last_rd_q;
    if (rd_grant) last_rd_d = pick_ic ? SRC_ICACHE : SRC_DCACHE;
  end

  always_ff @(posedge clk) begin
    if (rst) last_rd_q <= SRC_ICACHE;
    else     last_rd_q <= last_rd_d;
  end
`else
  assign pick_ic = irq_req_i && !dcache_rd_req_i;
`endif

  assign pick_dc  = dcache_rd_req_i && !pick_ic;
  assign rd_grant = (state_q == IDLE) && !dcache_wr_req_i && !ret_pending && (pick_ic || pick_dc);

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    addr_d     = addr_q;
    len_d      = len_q;
    ic_valid_d = 1'b0;
    dc_valid_d = 1'b0;
    ic_line_d  = ic_line_q;
    dc_line_d  = dc_line_q;
    pk_clear   = 1'b0;
    pk_load    = 1'b0;
    pk_beat    = 1'b0;
    pk_adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dcache_wr_req_i) begin
          pk_load = 1'b1;
          src_d   = SRC_DCACHE;
          addr_d  = dcache_wr_addr_i;
          len_d   = dcache_wr_len_i;
          state_d = WR_ADDR;
        end else if (rd_grant) begin
          pk_clear = 1'b1;
          state_d  = RD_ADDR;
          if (pick_dc) begin
            src_d  = SRC_DCACHE;
            addr_d = dcache_rd_addr_i;
            len_d  = dcache_rd_len_i;
          end else begin
            src_d  = SRC_ICACHE;
            addr_d = icache_rd_addr_i;
            len_d  = icache_rd_len_i;
          end
        end else begin
          src_d = SRC_NONE;
        end
      end
      RD_ADDR: if (mem_rd_rdy_i) state_d = RD_DATA;
      RD_DATA: begin
        if (mem_ret_valid_i) begin
          if (mem_ret_last_i) begin
            state_d = IDLE;
            if (src_q == SRC_ICACHE) begin
              ic_valid_d = 1'b1;
              ic_line_d  = pk_merged;
            end else begin
              dc_valid_d = 1'b1;
              dc_line_d  = pk_merged;
            end
          end else begin
            pk_beat = 1'b1;
          end
        end
      end
      WR_ADDR: if (mem_wr_rdy_i) state_d = WR_DATA;
      WR_DATA: begin
        if (mem_wdata_rdy_i) begin
          if (pk_at_len) state_d = WR_RESP;
          else           pk_adv  = 1'b1;
        end
      end
      WR_RESP: if (mem_wr_done_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      src_q      <= SRC_NONE;
      addr_q     <= '0;
      len_q      <= '0;
      ic_valid_q <= 1'b0;
      dc_valid_q <= 1'b0;
      ic_line_q  <= '0;
      dc_line_q  <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      ic_valid_q <= ic_valid_d;
      dc_valid_q <= dc_valid_d;
      ic_line_q  <= ic_line_d;
      dc_line_q  <= dc_line_d;
    end
  end

  arb_line_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (pk_clear),
    .load_i       (pk_load),
    .load_line_i  (dcache_wr_data_i),
    .beat_i       (pk_beat),
    .beat_data_i  (mem_ret_data_i),
    .adv_i        (pk_adv),
    .len_i        (len_q[1:0]),
    .line_merged_o(pk_merged),
    .wr_beat_o    (pk_wr_beat),
    .at_len_o     (pk_at_len)
  );

  assign dcache_wr_rdy_o    = (state_q == IDLE) && !rst;
  assign mem_rd_req_o       = (state_q == RD_ADDR) && !rst;
  assign mem_wr_req_o       = (state_q == WR_ADDR) && !rst;
  assign mem_wdata_valid_o  = (state_q == WR_DATA) && !rst;
  assign mem_wdata_last_o   = mem_wdata_valid_o && pk_at_len;
  assign mem_wdata_o        = mem_wdata_valid_o ? pk_wr_beat : '0;
  assign mem_rd_addr_o      = rst ? '0 : addr_q;
  assign mem_rd_len_o       = rst ? '0 : len_q;
  assign mem_wr_addr_o      = rst ? '0 : addr_q;
  assign mem_wr_len_o       = rst ? '0 : len_q;
  assign icache_ret_valid_o = ic_valid_q && !rst;
  assign dcache_ret_valid_o = dc_valid_q && !rst;
  assign icache_ret_data_o  = rst ? '0 : ic_line_q;
  assign dcache_ret_data_o  = rst ? '0 : dc_line_q;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Bench for cache_bus_arbiter: table-driven reads plus hand sequences,
// returned lines checked against a scoreboard queue.
module tb_cache_bus_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         irq_req_i;
  logic [31:0]  icache_rd_addr_i;
  logic [7:0]   icache_rd_len_i;
  logic         icache_ret_valid_o;
  logic [127:0] icache_ret_data_o;
  logic         dcache_rd_req_i;
  logic [31:0]  dcache_rd_addr_i;
  logic [7:0]   dcache_rd_len_i;
  logic         dcache_ret_valid_o;
  logic [127:0] dcache_ret_data_o;
  logic         dcache_wr_req_i;
  logic [31:0]  dcache_wr_addr_i;
  logic [127:0] dcache_wr_data_i;
  logic [7:0]   dcache_wr_len_i;
  logic         dcache_wr_rdy_o;
  logic         mem_rd_req_o;
  logic [31:0]  mem_rd_addr_o;
  logic [7:0]   mem_rd_len_o;
  logic         mem_rd_rdy_i;
  logic         mem_ret_valid_i;
  logic         mem_ret_last_i;
  logic [31:0]  mem_ret_data_i;
  logic         mem_wr_req_o;
  logic [31:0]  mem_wr_addr_o;
  logic [7:0]   mem_wr_len_o;
  logic         mem_wr_rdy_i;
  logic         mem_wdata_valid_o;
  logic [31:0]  mem_wdata_o;
  logic         mem_wdata_last_o;
  logic         mem_wdata_rdy_i;
  logic         mem_wr_done_i;

  always #5 clk = ~clk;

  cache_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .irq_req_i(irq_req_i), .icache_rd_addr_i(icache_rd_addr_i), .icache_rd_len_i(icache_rd_len_i),
    .icache_ret_valid_o(icache_ret_valid_o), .icache_ret_data_o(icache_ret_data_o),
    .dcache_rd_req_i(dcache_rd_req_i), .dcache_rd_addr_i(dcache_rd_addr_i), .dcache_rd_len_i(dcache_rd_len_i),
    .dcache_ret_valid_o(dcache_ret_valid_o), .dcache_ret_data_o(dcache_ret_data_o),
    .dcache_wr_req_i(dcache_wr_req_i), .dcache_wr_addr_i(dcache_wr_addr_i),
    .dcache_wr_data_i(dcache_wr_data_i), .dcache_wr_len_i(dcache_wr_len_i), .dcache_wr_rdy_o(dcache_wr_rdy_o),
    .mem_rd_req_o(mem_rd_req_o), .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_len_o(mem_rd_len_o),
    .mem_rd_rdy_i(mem_rd_rdy_i), .mem_ret_valid_i(mem_ret_valid_i), .mem_ret_last_i(mem_ret_last_i),
    .mem_ret_data_i(mem_ret_data_i),
    .mem_wr_req_o(mem_wr_req_o), .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_len_o(mem_wr_len_o),
    .mem_wr_rdy_i(mem_wr_rdy_i), .mem_wdata_valid_o(mem_wdata_valid_o), .mem_wdata_o(mem_wdata_o),
    .mem_wdata_last_o(mem_wdata_last_o), .mem_wdata_rdy_i(mem_wdata_rdy_i), .mem_wr_done_i(mem_wr_done_i)
  );

  typedef struct packed {
    logic         is_ic;
    logic [31:0]  addr;
    logic [7:0]   len;
    int unsigned  nbeats;
    logic [3:0][31:0] beats;
    int unsigned  stall;
    logic [127:0] exp;
  } rd_vec_t;

  typedef struct packed {
    logic         is_ic;
    logic [127:0] line;
  } sb_t;

  sb_t          sb[$];
  sb_t          sb_e;
  rd_vec_t      vec [5];
  int unsigned  tests = 0;
  int unsigned  fails = 0;
  logic         prev_ic_v = 1'b0, prev_dc_v = 1'b0;
  logic [127:0] prev_ic_d = '0, prev_dc_d = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard monitor: every return pulse must match the oldest expected line.
  always @(negedge clk) begin
    if (!rst) begin
      if (icache_ret_valid_o || dcache_ret_valid_o) begin
        chk("ret_onehot", {127'd0, icache_ret_valid_o && dcache_ret_valid_o}, 128'd0);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL ret_unexpected: got ic=%0b dc=%0b expected no pulse at %0t",
                   icache_ret_valid_o, dcache_ret_valid_o, $time);
        end else begin
          sb_e = sb.pop_front();
          chk("ret_src", {127'd0, icache_ret_valid_o}, {127'd0, sb_e.is_ic});
          chk("ret_data", sb_e.is_ic ? icache_ret_data_o : dcache_ret_data_o, sb_e.line);
        end
      end
      if (prev_ic_v && !icache_ret_valid_o) chk("ic_data_hold", icache_ret_data_o, prev_ic_d);
      if (prev_dc_v && !dcache_ret_valid_o) chk("dc_data_hold", dcache_ret_data_o, prev_dc_d);
    end
    prev_ic_v = icache_ret_valid_o;
    prev_dc_v = dcache_ret_valid_o;
    prev_ic_d = icache_ret_data_o;
    prev_dc_d = dcache_ret_data_o;
  end

  task automatic wait_rd_req(output logic ok);
    int unsigned w = 0;
    while (!mem_rd_req_o && w < 50) begin
      tick();
      w++;
    end
    ok = mem_rd_req_o;
    if (!ok) timeout("rd_req_wait");
  endtask

  // Plays the memory side of one read, then drops the served request.
  task automatic serve_read(input logic is_ic, input logic [31:0] addr, input logic [7:0] len,
                            input int unsigned nb, input logic [3:0][31:0] beats,
                            input int unsigned stall, input logic [127:0] exp);
    logic ok;
    wait_rd_req(ok);
    if (ok) begin
      chk("rd_addr", {96'd0, mem_rd_addr_o}, {96'd0, addr});
      chk("rd_len", {120'd0, mem_rd_len_o}, {120'd0, len});
      for (int unsigned s = 0; s < stall; s++) begin
        tick();
        chk("rd_req_held", {127'd0, mem_rd_req_o}, 128'd1);
        chk("rd_addr_stable", {96'd0, mem_rd_addr_o}, {96'd0, addr});
      end
      mem_rd_rdy_i = 1'b1;
      tick();
      mem_rd_rdy_i = 1'b0;
      sb.push_back('{is_ic: is_ic, line: exp});
      for (int unsigned b = 0; b < nb; b++) begin
        mem_ret_valid_i = 1'b1;
        mem_ret_data_i  = beats[b];
        mem_ret_last_i  = (b == nb - 1);
        tick();
      end
      mem_ret_valid_i = 1'b0;
      mem_ret_last_i  = 1'b0;
      mem_ret_data_i  = '0;
    end
    if (is_ic) irq_req_i = 1'b0;
    else       dcache_rd_req_i = 1'b0;
  endtask

  task automatic serve_write(input logic [31:0] addr, input logic [7:0] len, input logic [127:0] data,
                             input int unsigned stall, input int unsigned done_delay);
    int unsigned  w;
    logic [127:0] sh;
    dcache_wr_req_i  = 1'b1;
    dcache_wr_addr_i = addr;
    dcache_wr_data_i = data;
    dcache_wr_len_i  = len;
    w = 0;
    while (!dcache_wr_rdy_o && w < 50) begin tick(); w++; end
    if (!dcache_wr_rdy_o) timeout("wr_rdy_wait");
    tick();
    dcache_wr_req_i  = 1'b0;
    dcache_wr_data_i = '0;
    w = 0;
    while (!mem_wr_req_o && w < 50) begin tick(); w++; end
    if (!mem_wr_req_o) begin
      timeout("wr_req_wait");
      return;
    end
    chk("wr_addr", {96'd0, mem_wr_addr_o}, {96'd0, addr});
    chk("wr_len", {120'd0, mem_wr_len_o}, {120'd0, len});
    mem_wr_rdy_i = 1'b1;
    tick();
    mem_wr_rdy_i = 1'b0;
    for (int unsigned b = 0; b <= len; b++) begin
      sh = data >> (32 * b);
      chk("wdata_valid", {127'd0, mem_wdata_valid_o}, 128'd1);
      chk("wdata", {96'd0, mem_wdata_o}, {96'd0, sh[31:0]});
      chk("wdata_last", {127'd0, mem_wdata_last_o}, {127'd0, b == len});
      for (int unsigned s = 0; s < ((b == 0) ? stall : 0); s++) begin
        tick();
        chk("wdata_stable", {95'd0, mem_wdata_valid_o, mem_wdata_o}, {95'd1, sh[31:0]});
      end
      mem_wdata_rdy_i = 1'b1;
      tick();
      mem_wdata_rdy_i = 1'b0;
    end
    for (int unsigned d = 0; d < done_delay; d++) begin
      chk("no_rd_before_done", {126'd0, mem_rd_req_o, mem_wdata_valid_o}, 128'd0);
      tick();
    end
    mem_wr_done_i = 1'b1;
    tick();
    mem_wr_done_i = 1'b0;
  endtask

  initial begin
    logic ok;
    rst = 1'b1;
    irq_req_i = 0; icache_rd_addr_i = '0; icache_rd_len_i = '0;
    dcache_rd_req_i = 0; dcache_rd_addr_i = '0; dcache_rd_len_i = '0;
    dcache_wr_req_i = 0; dcache_wr_addr_i = '0; dcache_wr_data_i = '0; dcache_wr_len_i = '0;
    mem_rd_rdy_i = 0; mem_ret_valid_i = 0; mem_ret_last_i = 0; mem_ret_data_i = '0;
    mem_wr_rdy_i = 0; mem_wdata_rdy_i = 0; mem_wr_done_i = 0;

    vec[0] = '{1'b0, 32'h0000_D000, 8'd3, 4,
               {32'h34567891, 32'h02345678, 32'h91023456, 32'h78910234}, 0,
               128'h34567891_02345678_91023456_78910234};
    vec[1] = '{1'b0, 32'h1000_0004, 8'd0, 1,
               {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, 0,
               128'h00000000_00000000_00000000_DEADBEEF};
    vec[2] = '{1'b1, 32'h0000_2040, 8'd3, 4,
               {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 5,
               128'h44444444_33333333_22222222_11111111};
    vec[3] = '{1'b1, 32'h0000_2080, 8'd3, 2,
               {32'h0, 32'h0, 32'hBBBB0002, 32'hAAAA0001}, 0,
               128'h00000000_00000000_BBBB0002_AAAA0001};
    vec[4] = '{1'b0, 32'h0000_4000, 8'd1, 2,
               {32'h0, 32'h0, 32'h0000F00D, 32'hCAFE0000}, 0,
               128'h00000000_00000000_0000F00D_CAFE0000};

    repeat (2) tick();
    chk("rst_wr_rdy", {127'd0, dcache_wr_rdy_o}, 128'd0);
    chk("rst_reqs", {124'd0, mem_rd_req_o, mem_wr_req_o, mem_wdata_valid_o, mem_wdata_last_o}, 128'd0);
    chk("rst_ret_valid", {126'd0, icache_ret_valid_o, dcache_ret_valid_o}, 128'd0);
    chk("rst_ic_data", icache_ret_data_o, 128'd0);
    chk("rst_dc_data", dcache_ret_data_o, 128'd0);
    chk("rst_mem_addr", {32'd0, mem_rd_addr_o, mem_wr_addr_o, mem_wdata_o}, 128'd0);
    rst = 1'b0;
    tick();
    chk("idle_wr_rdy", {127'd0, dcache_wr_rdy_o}, 128'd1);

    for (int i = 0; i < 5; i++) begin
      if (vec[i].is_ic) begin
        irq_req_i = 1'b1; icache_rd_addr_i = vec[i].addr; icache_rd_len_i = vec[i].len;
      end else begin
        dcache_rd_req_i = 1'b1; dcache_rd_addr_i = vec[i].addr; dcache_rd_len_i = vec[i].len;
      end
      serve_read(vec[i].is_ic, vec[i].addr, vec[i].len, vec[i].nbeats, vec[i].beats,
                 vec[i].stall, vec[i].exp);
    end

    // Simultaneous reads; the last served source above was the dcache.
    irq_req_i = 1'b1; icache_rd_addr_i = 32'h0000_5000; icache_rd_len_i = 8'd0;
    dcache_rd_req_i = 1'b1; dcache_rd_addr_i = 32'h0000_6000; dcache_rd_len_i = 8'd0;
`ifdef ARB_RR_EN
    serve_read(1'b1, 32'h0000_5000, 8'd0, 1, {96'd0, 32'h1C1C1C1C}, 0, {96'd0, 32'h1C1C1C1C});
    serve_read(1'b0, 32'h0000_6000, 8'd0, 1, {96'd0, 32'hDCDCDCDC}, 0, {96'd0, 32'hDCDCDCDC});
`else
    serve_read(1'b0, 32'h0000_6000, 8'd0, 1, {96'd0, 32'hDCDCDCDC}, 0, {96'd0, 32'hDCDCDCDC});
    serve_read(1'b1, 32'h0000_5000, 8'd0, 1, {96'd0, 32'h1C1C1C1C}, 0, {96'd0, 32'h1C1C1C1C});
`endif

    // Write-back with a dcache read pending behind it.
    dcache_rd_req_i = 1'b1; dcache_rd_addr_i = 32'h0000_7000; dcache_rd_len_i = 8'd3;
    serve_write(32'h2468_7570, 8'd3, 128'h12345678_91023456_78910234_33333333, 5, 3);
    serve_read(1'b0, 32'h0000_7000, 8'd3, 4,
               {32'h77770003, 32'h77770002, 32'h77770001, 32'h77770000}, 0,
               128'h77770003_77770002_77770001_77770000);

    // Reset in the middle of a read after two beats.
    dcache_rd_req_i = 1'b1; dcache_rd_addr_i = 32'h0000_3000; dcache_rd_len_i = 8'd3;
    wait_rd_req(ok);
    if (ok) begin
      mem_rd_rdy_i = 1'b1; tick(); mem_rd_rdy_i = 1'b0;
      for (int b = 0; b < 2; b++) begin
        mem_ret_valid_i = 1'b1; mem_ret_data_i = 32'hEEEE0000 + b; tick();
      end
      mem_ret_valid_i = 1'b0; mem_ret_data_i = '0;
      rst = 1'b1;
      tick();
      chk("mid_rst_rd_req", {127'd0, mem_rd_req_o}, 128'd0);
      chk("mid_rst_wr_rdy", {127'd0, dcache_wr_rdy_o}, 128'd0);
      chk("mid_rst_ret", {127'd0, dcache_ret_valid_o}, 128'd0);
      rst = 1'b0;
    end
    serve_read(1'b0, 32'h0000_3000, 8'd3, 4,
               {32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A}, 0,
               128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A);

    repeat (3) tick();
    chk("sb_drained", {96'd0, sb.size()}, 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
